// File: rtl/gelato_exec_dispatch_queue_if.sv
// Dispatch-queue bus: collector-side push channel plus per-unit execute hand-off.
// "master" is the collector/execute side; "slave" is the queue.
interface gelato_exec_dispatch_queue_if #(
   parameter int DEPTH      = 4,
   parameter int NUM_SRC    = 3,
   parameter int INST_WIDTH = 64,
   parameter int REG_WIDTH  = 1024,
   parameter int NUM_UNITS  = 4
);
   localparam int UNIT_W = $clog2(NUM_UNITS);
   localparam int CW     = $clog2(DEPTH + 1);

   logic                           in_valid;
   logic                           in_ready;
   logic [UNIT_W-1:0]              in_unit;
   logic [INST_WIDTH-1:0]          in_inst;
   logic [NUM_SRC*REG_WIDTH-1:0]   in_src;
   logic [NUM_UNITS-1:0]           out_valid;
   logic [NUM_UNITS-1:0]           out_ready;
   logic [INST_WIDTH-1:0]          out_inst;
   logic [NUM_SRC*REG_WIDTH-1:0]   out_src;
   logic                           bad_unit;
   logic [CW-1:0]                  count;

   modport master (
      output in_valid, in_unit, in_inst, in_src, out_ready,
      input  in_ready, out_valid, out_inst, out_src, bad_unit, count
   );

   modport slave (
      input  in_valid, in_unit, in_inst, in_src, out_ready,
      output in_ready, out_valid, out_inst, out_src, bad_unit, count
   );
endinterface

// File: rtl/gelato_exec_dispatch_queue.sv
// In-order dispatch FIFO steering the head entry to one of NUM_UNITS execute channels.
// Define GELATO_DISPATCH_BYPASS_EN for a same-cycle bypass when the queue is empty.
module gelato_exec_dispatch_queue #(
   parameter int DEPTH      = 4,
   parameter int NUM_SRC    = 3,
   parameter int INST_WIDTH = 64,
   parameter int REG_WIDTH  = 1024,
   parameter int NUM_UNITS  = 4
) (
   input logic                     clk,
   input logic                     rst,
   gelato_exec_dispatch_queue_if.slave dq
);
   localparam int UNIT_W = $clog2(NUM_UNITS);
   localparam int PW     = $clog2(DEPTH);
   localparam int CW     = $clog2(DEPTH + 1);
   localparam int SW     = NUM_SRC * REG_WIDTH;

   typedef struct packed {
      logic [UNIT_W-1:0]     unit;
      logic [INST_WIDTH-1:0] inst;
      logic [SW-1:0]         src;
   } entry_t;

   entry_t               mem [DEPTH];
   entry_t               head;
   logic [PW-1:0]        rd_ptr, wr_ptr;
   logic [CW-1:0]        count_q;
   logic                 bad_q;
   logic                 nonempty, head_ok_unit;
   logic                 pop_norm, pop_force, pop, push, push_w;
   logic [NUM_UNITS-1:0] q_vld;

   assign head     = mem[rd_ptr];
   assign nonempty = (count_q != '0);

   // Out-of-range unit indices only exist when NUM_UNITS is not a power of two.
   generate
      if (NUM_UNITS == (1 << UNIT_W)) begin : g_head_pow2
         assign head_ok_unit = 1'b1;
      end else begin : g_head_npow2
         localparam logic [UNIT_W-1:0] NU = UNIT_W'(NUM_UNITS);
         assign head_ok_unit = (head.unit < NU);
      end
   endgenerate

   assign q_vld     = (nonempty && head_ok_unit) ? (NUM_UNITS'(1) << head.unit) : '0;
   assign pop_norm  = |(q_vld & dq.out_ready);
   assign pop_force = nonempty && !head_ok_unit;
   assign pop       = pop_norm || pop_force;
   assign push      = dq.in_valid && dq.in_ready;

`ifdef GELATO_DISPATCH_BYPASS_EN
   logic                 in_ok_unit, byp, byp_take;
   logic [NUM_UNITS-1:0] byp_vld;

   generate
      if (NUM_UNITS == (1 << UNIT_W)) begin : g_in_pow2
         assign in_ok_unit = 1'b1;
      end else begin : g_in_npow2
         localparam logic [UNIT_W-1:0] NU = UNIT_W'(NUM_UNITS);
         assign in_ok_unit = (dq.in_unit < NU);
      end
   endgenerate

   // Empty queue: present the incoming entry directly; it is only stored if not taken.
   assign byp          = !nonempty && dq.in_valid && in_ok_unit;
   assign byp_vld      = byp ? (NUM_UNITS'(1) << dq.in_unit) : '0;
   assign byp_take     = |(byp_vld & dq.out_ready);
   assign dq.out_valid = byp ? byp_vld : q_vld;
   assign dq.out_inst  = byp ? dq.in_inst : head.inst;
   assign dq.out_src   = byp ? dq.in_src : head.src;
   assign push_w       = push && !byp_take;
`else
   assign dq.out_valid = q_vld;
   assign dq.out_inst  = head.inst;
   assign dq.out_src   = head.src;
   assign push_w       = push;
`endif

   assign dq.in_ready = (count_q != CW'(DEPTH));
   assign dq.count    = count_q;
   assign dq.bad_unit = bad_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
         bad_q   <= 1'b0;
      end else begin
         bad_q <= pop_force;
         if (push_w) wr_ptr <= wr_ptr + PW'(1);
         if (pop)    rd_ptr <= rd_ptr + PW'(1);
         if (push_w && !pop)      count_q <= count_q + CW'(1);
         else if (!push_w && pop) count_q <= count_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push_w) mem[wr_ptr] <= {dq.in_unit, dq.in_inst, dq.in_src};
   end
endmodule

// File: tb/tb_gelato_exec_dispatch_queue.sv
// Bench for gelato_exec_dispatch_queue: a 4-unit and a 3-unit instance, checked each cycle
// against a queue-based model, plus directed literal expectations.
`timescale 1ns/1ps
module tb_gelato_exec_dispatch_queue;
   localparam int DEPTH = 4, NSRC = 3, IW = 64, RW = 32, SW = NSRC * RW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   gelato_exec_dispatch_queue_if #(.DEPTH(DEPTH), .NUM_SRC(NSRC), .INST_WIDTH(IW),
      .REG_WIDTH(RW), .NUM_UNITS(4)) b0 ();
   gelato_exec_dispatch_queue_if #(.DEPTH(DEPTH), .NUM_SRC(NSRC), .INST_WIDTH(IW),
      .REG_WIDTH(RW), .NUM_UNITS(3)) b1 ();

   gelato_exec_dispatch_queue #(.DEPTH(DEPTH), .NUM_SRC(NSRC), .INST_WIDTH(IW),
      .REG_WIDTH(RW), .NUM_UNITS(4)) u0 (.clk(clk), .rst(rst), .dq(b0.slave));
   gelato_exec_dispatch_queue #(.DEPTH(DEPTH), .NUM_SRC(NSRC), .INST_WIDTH(IW),
      .REG_WIDTH(RW), .NUM_UNITS(3)) u1 (.clk(clk), .rst(rst), .dq(b1.slave));

   logic          iv   [2];
   logic [1:0]    iu   [2];
   logic [IW-1:0] ii   [2];
   logic [SW-1:0] isrc [2];
   logic [3:0]    ordy [2];
   logic          irdy [2];
   logic [3:0]    ov   [2];
   logic [IW-1:0] oi   [2];
   logic [SW-1:0] os   [2];
   logic          bad  [2];
   logic [2:0]    cnt  [2];

   assign b0.in_valid  = iv[0];
   assign b0.in_unit   = iu[0];
   assign b0.in_inst   = ii[0];
   assign b0.in_src    = isrc[0];
   assign b0.out_ready = ordy[0];
   assign b1.in_valid  = iv[1];
   assign b1.in_unit   = iu[1];
   assign b1.in_inst   = ii[1];
   assign b1.in_src    = isrc[1];
   assign b1.out_ready = ordy[1][2:0];
   assign irdy[0] = b0.in_ready;   assign irdy[1] = b1.in_ready;
   assign ov[0]   = b0.out_valid;  assign ov[1]   = {1'b0, b1.out_valid};
   assign oi[0]   = b0.out_inst;   assign oi[1]   = b1.out_inst;
   assign os[0]   = b0.out_src;    assign os[1]   = b1.out_src;
   assign bad[0]  = b0.bad_unit;   assign bad[1]  = b1.bad_unit;
   assign cnt[0]  = b0.count;      assign cnt[1]  = b1.count;

   int pass = 0, total = 0;

   task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else pass++;
   endtask

   // Reference model: an ordered list of pending entries per instance.
   typedef struct {
      int            unit;
      logic [IW-1:0] inst;
      logic [SW-1:0] src;
   } ent_t;

   ent_t mq [2][$];
   logic mbad [2];
   bit   mlive = 0;

   function automatic int nu(int i);
      return (i == 0) ? 4 : 3;
   endfunction

   initial forever begin
      @(posedge clk);
      if (rst) begin
         mlive = 1;
         for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            mbad[i] = 1'b0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            bit   take, popn, forced, pushing;
            ent_t e;
            take = 0; popn = 0; forced = 0;
`ifdef GELATO_DISPATCH_BYPASS_EN
            if (mq[i].size() == 0 && iv[i] && int'(iu[i]) < nu(i) && ordy[i][iu[i]]) take = 1;
`endif
            if (mq[i].size() > 0) begin
               if (mq[i][0].unit < nu(i)) popn = ordy[i][mq[i][0].unit];
               else forced = 1;
            end
            pushing = iv[i] && (mq[i].size() != DEPTH) && !take;
            if (popn || forced) void'(mq[i].pop_front());
            if (pushing) begin
               e.unit = int'(iu[i]); e.inst = ii[i]; e.src = isrc[i];
               mq[i].push_back(e);
            end
            mbad[i] = forced;
         end
      end
   end

   // Per-cycle comparison against the model, away from the rising edge.
   initial forever begin
      @(negedge clk);
      if (mlive) begin
         for (int i = 0; i < 2; i++) begin
            logic [3:0]    eov;
            logic [IW-1:0] ei;
            logic [SW-1:0] es;
            eov = '0; ei = '0; es = '0;
            if (mq[i].size() > 0) begin
               if (mq[i][0].unit < nu(i)) begin
                  eov = 4'(1 << mq[i][0].unit);
                  ei  = mq[i][0].inst;
                  es  = mq[i][0].src;
               end
            end
`ifdef GELATO_DISPATCH_BYPASS_EN
            else if (iv[i] && int'(iu[i]) < nu(i)) begin
               eov = 4'(1 << iu[i]);
               ei  = ii[i];
               es  = isrc[i];
            end
`endif
            chk($sformatf("u%0d count", i), cnt[i], mq[i].size());
            chk($sformatf("u%0d in_ready", i), irdy[i], mq[i].size() != DEPTH);
            chk($sformatf("u%0d out_valid", i), ov[i], eov);
            chk($sformatf("u%0d bad_unit", i), bad[i], mbad[i]);
            if (eov != 0) begin
               chk($sformatf("u%0d out_inst", i), oi[i], ei);
               chk($sformatf("u%0d out_src", i), os[i], es);
            end
         end
      end
   end

   task automatic cyc(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         iv[i] = 0; iu[i] = '0; ii[i] = '0; isrc[i] = '0; ordy[i] = '0;
      end
      cyc(2);
      rst = 0;
      chk("reset count", cnt[0], 0);
      chk("reset in_ready", irdy[0], 1);
      chk("reset out_valid", ov[0], 0);
      chk("reset bad_unit", bad[1], 0);

      // Single instruction to unit 2.
      iv[0] = 1; iu[0] = 2; ii[0] = 64'h11; isrc[0] = {32'd3, 32'd2, 32'd1}; ordy[0] = 4'b0100;
`ifdef GELATO_DISPATCH_BYPASS_EN
      #1;
      chk("t1 bypass out_valid", ov[0], 4'b0100);
      chk("t1 bypass out_src", os[0], {32'd3, 32'd2, 32'd1});
      cyc();
      iv[0] = 0;
`else
      cyc();
      iv[0] = 0;
      chk("t1 out_valid", ov[0], 4'b0100);
      chk("t1 out_inst", oi[0], 64'h11);
      chk("t1 out_src", os[0], {32'd3, 32'd2, 32'd1});
      cyc();
`endif
      chk("t1 drained", cnt[0], 0);

      // Fill to full, hold a fifth, then drain in order.
      ordy[0] = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         iv[0] = 1; iu[0] = 2'(k); ii[0] = 64'h20 + 64'(k); isrc[0] = {3{32'(k)}};
         cyc();
      end
      chk("t2 full count", cnt[0], 4);
      chk("t2 full in_ready", irdy[0], 0);
      iu[0] = 0; ii[0] = 64'h24;
      cyc(2);
      chk("t2 held count", cnt[0], 4);
      ordy[0] = 4'hF;
      cyc();
      chk("t2 first pop count", cnt[0], 3);
      chk("t2 ready after pop", irdy[0], 1);
      chk("t2 head order", oi[0], 64'h21);
      cyc();
      iv[0] = 0;
      chk("t2 push+pop count", cnt[0], 3);
      cyc(4);
      chk("t2 drained", cnt[0], 0);

      // Stalled head blocks a later entry whose unit is ready.
      ordy[0] = 4'b0000;
      iv[0] = 1; iu[0] = 1; ii[0] = 64'h31; cyc();
      iu[0] = 0; ii[0] = 64'h30; cyc();
      iv[0] = 0; ordy[0] = 4'b0001;
      for (int k = 0; k < 4; k++) begin
         chk("t3 blocked valid", ov[0], 4'b0010);
         chk("t3 stable inst", oi[0], 64'h31);
         cyc();
      end
      ordy[0] = 4'b0010; cyc();
      chk("t3 next valid", ov[0], 4'b0001);
      chk("t3 next inst", oi[0], 64'h30);
      ordy[0] = 4'b0001; cyc();
      chk("t3 drained", cnt[0], 0);

      // Out-of-range unit on the 3-unit instance.
      ordy[1] = 4'b0000;
      iv[1] = 1; iu[1] = 3; ii[1] = 64'h43; cyc();
      chk("t4 bad entry hidden", ov[1], 0);
      iu[1] = 0; ii[1] = 64'h40; cyc();
      chk("t4 bad pulse", bad[1], 1);
      chk("t4 count", cnt[1], 1);
      chk("t4 next valid", ov[1], 4'b0001);
      chk("t4 next inst", oi[1], 64'h40);
      iv[1] = 0; cyc();
      chk("t4 pulse ends", bad[1], 0);
      ordy[1] = 4'b0001; cyc();
      chk("t4 drained", cnt[1], 0);
      ordy[1] = 4'b0000;

      // Steady push+pop at occupancy 2; pointers wrap several times.
      ordy[0] = 4'b0000;
      for (int k = 0; k < 2; k++) begin
         iv[0] = 1; iu[0] = 2'(k); ii[0] = 64'h50 + 64'(k); isrc[0] = {$urandom, $urandom, $urandom};
         cyc();
      end
      ordy[0] = 4'hF;
      for (int k = 2; k < 22; k++) begin
         iu[0] = 2'(k % 4); ii[0] = 64'h50 + 64'(k); isrc[0] = {$urandom, $urandom, $urandom};
         cyc();
         chk("t5 steady count", cnt[0], 2);
      end
      iv[0] = 0;
      cyc(3);
      chk("t5 drained", cnt[0], 0);

      // Reset mid-operation discards entries; the push in that cycle is ignored.
      ordy[0] = 4'b0000;
      iv[0] = 1; iu[0] = 3; ii[0] = 64'h70; cyc();
      ii[0] = 64'h71; cyc();
      ii[0] = 64'h72; rst = 1; cyc();
      rst = 0; iv[0] = 0;
      chk("t6 reset count", cnt[0], 0);
      chk("t6 reset out_valid", ov[0], 0);
      chk("t6 reset in_ready", irdy[0], 1);
      cyc();
      chk("t6 still empty", cnt[0], 0);

`ifdef GELATO_DISPATCH_BYPASS_EN
      // Bypass taken, then bypass offered but not taken.
      ordy[0] = 4'b0010; iv[0] = 1; iu[0] = 1; ii[0] = 64'h61;
      #1;
      chk("t7 bypass valid", ov[0], 4'b0010);
      chk("t7 bypass inst", oi[0], 64'h61);
      cyc();
      iv[0] = 0;
      chk("t7 bypass count", cnt[0], 0);
      ordy[0] = 4'b0000; iv[0] = 1; ii[0] = 64'h62;
      #1;
      chk("t7 offer valid", ov[0], 4'b0010);
      cyc();
      iv[0] = 0;
      chk("t7 stored count", cnt[0], 1);
      chk("t7 queued valid", ov[0], 4'b0010);
      chk("t7 queued inst", oi[0], 64'h62);
      ordy[0] = 4'b0010; cyc();
      chk("t7 drained", cnt[0], 0);
`endif

      cyc(2);
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule

// File: doc/gelato_exec_dispatch_queue.md
# gelato_exec_dispatch_queue

In-order dispatch buffer between the operand collector and the execute units, generalising the single-channel valid/inst/src1–src3 hand-off. It accepts one fully-collected instruction per cycle with a parametrised number of source operands, and holds up to DEPTH entries. It steers the head entry to one of NUM_UNITS execution channels, each with its own valid/ready handshake. Entries whose unit index is out of range are discarded with an error pulse.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2.
- NUM_SRC, 3: source operands per instruction.
- INST_WIDTH, 64: packed instruction width.
- REG_WIDTH, 1024: warp register width (32 lanes × 32 b).
- NUM_UNITS, 4: execution channels, ≥2.
- UNIT_W, $clog2(NUM_UNITS): unit-index width (derived).
- clk  input  1  clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  collector offers an instruction.
- in_ready  output  1  queue can accept.
- in_unit  input  UNIT_W  target execution channel.
- in_inst  input  INST_WIDTH  instruction.
- in_src  input  NUM_SRC*REG_WIDTH  operands; src k at [k*REG_WIDTH +: REG_WIDTH].
- out_valid  output  NUM_UNITS  one-hot; head offered to that unit.
- out_ready  input  NUM_UNITS  per-unit accept.
- out_inst  output  INST_WIDTH  head instruction; shared by all units.
- out_src  output  NUM_SRC*REG_WIDTH  head operands; shared.
- bad_unit  output  1  one-cycle pulse when an out-of-range entry is dropped.
- count  output  $clog2(DEPTH+1)  current occupancy.

## Operation
- Circular FIFO with rd_ptr/wr_ptr of $clog2(DEPTH) bits and a count register. Pointers wrap modulo DEPTH.
- Push: in_valid && in_ready. in_ready = (count != DEPTH). It is not combinationally dependent on out_ready, so a full queue refuses input even when it pops in the same cycle.
- Each entry stores {unit, inst, src}.
- Head decode: when count > 0 and head.unit < NUM_UNITS, out_valid = 1 << head.unit. Otherwise out_valid = 0.
- Pop:
  - Normal pop when out_valid[head.unit] && out_ready[head.unit].
  - Forced pop when count > 0 and head.unit ≥ NUM_UNITS. This applies only when NUM_UNITS is not a power of two.
  - A forced pop registers bad_unit = 1 for the next cycle.
- Strict in-order dispatch: a stalled head blocks all later entries, even those targeting ready units.
- out_valid[u], once asserted, holds with stable out_inst/out_src until the handshake completes.
- Readiness of non-target units is ignored.
- out_inst/out_src are don't-care when out_valid = 0. The bench must not check them then.
- Simultaneous push and pop: count unchanged, both pointers advance.

## Timing
- Reset values:
  - count = 0, rd_ptr = wr_ptr = 0.
  - out_valid = 0, bad_unit = 0, in_ready = 1 from the first cycle after reset.
  - Entry storage is not reset.
- Latency: an entry pushed in cycle N can be offered (out_valid high) in cycle N+1 at the earliest.
- Throughput: one push and one pop per cycle sustained.
- Full (count = DEPTH): in_ready = 0; a pop that cycle makes in_ready = 1 in the next cycle.
- Empty: out_valid = 0 regardless of out_ready.
- Reset asserted mid-operation discards all entries and pending pulses on the next edge. Push/pop in that cycle are ignored.
- count, out_valid, in_ready derive from registered state. The only combinational input→output path is out_ready → (nothing); pop affects outputs next cycle.

## Configuration
- GELATO_DISPATCH_BYPASS_EN defined: when count = 0, in_valid = 1 and in_unit < NUM_UNITS, the input is presented combinationally that same cycle.
  - out_valid = 1 << in_unit; out_inst/out_src = in_inst/in_src.
  - If out_ready[in_unit] = 1, the entry is consumed without being written and count stays 0.
  - If out_ready[in_unit] = 0, the entry is written normally and offered from the queue next cycle.
  - Out-of-range input is never bypassed.
- Undefined: no bypass; minimum latency is 1 cycle as stated in Timing.

## Test plan
- Reset, then push inst=0x11 unit=2 src={1,2,3} with out_ready=4'b0100 → cycle+1: out_valid=4'b0100, out_inst=0x11; cycle+2: count=0.
- out_ready=0, push 4 entries → count=4, in_ready=0; 5th in_valid held; raise out_ready=4'hF → one pop per cycle, in_ready=1 one cycle after first pop, order preserved 0..4.
- Head targets unit 1 (stalled), next targets unit 0 (ready) → unit 0 never sees valid until unit 1 accepts; out_inst stable throughout.
- NUM_UNITS=3, push unit=3 then unit=0 → bad_unit single pulse, unit 3 entry never on out_valid, unit 0 entry dispatched next.
- Steady push+pop with count=2 for 20 cycles → count constant 2, pointers wrap, data matches.
- With GELATO_DISPATCH_BYPASS_EN, empty queue, push unit=1 with out_ready[1]=1 → out_valid=4'b0010 same cycle, count stays 0; repeat with out_ready=0 → count=1, offered next cycle.
